// File: rtl/mem_model_pkg.sv
// Shared defaults, latency bounds and lane layout for the memory latency model.
// Also provides a latency legality helper for elaboration checks.
package mem_model_pkg;

   localparam int DATA_W_DEF  = 19;
   localparam int ADDR_W_DEF  = 19;
   localparam int DEPTH_DEF   = 256;
   localparam int LATENCY_DEF = 1;
   localparam int LATENCY_MIN = 1;
   localparam int LATENCY_MAX = 4;
   localparam int LANE0_MSB   = 7;

   // Byte-enable encoding: bit 0 selects the low lane, bit 1 the upper lane.
   typedef enum logic [1:0] {
      LANE_NONE = 2'b00,
      LANE_LO   = 2'b01,
      LANE_HI   = 2'b10,
      LANE_ALL  = 2'b11
   } lane_sel_e;

   function automatic bit latency_legal(input int lat);
      return (lat >= LATENCY_MIN) && (lat <= LATENCY_MAX);
   endfunction

endpackage

// File: rtl/mem_latency_model_if.sv
// Fetch port, data port and IMEM backdoor of the memory latency model.
// The master side issues requests; the slave side is the memory model.
interface mem_latency_model_if
   import mem_model_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
);

   logic              instr_mem_req_i;
   logic [ADDR_W-1:0] instr_mem_addr_i;
   logic [DATA_W-1:0] instr_mem_rd_data_o;
   logic              instr_mem_rd_valid_o;

   logic              data_mem_req_i;
   logic [ADDR_W-1:0] data_mem_addr_i;
   logic              data_mem_wr_i;
   logic [1:0]        data_mem_byte_en_i;
   logic [DATA_W-1:0] data_mem_wr_data_i;
   logic [DATA_W-1:0] data_mem_rd_data_o;
   logic              data_mem_rd_valid_o;
   logic              data_mem_err_o;

   logic              init_we_i;
   logic [ADDR_W-1:0] init_addr_i;
   logic [DATA_W-1:0] init_data_i;

   modport master (
      output instr_mem_req_i, instr_mem_addr_i,
      input  instr_mem_rd_data_o, instr_mem_rd_valid_o,
      output data_mem_req_i, data_mem_addr_i, data_mem_wr_i,
      output data_mem_byte_en_i, data_mem_wr_data_i,
      input  data_mem_rd_data_o, data_mem_rd_valid_o, data_mem_err_o,
      output init_we_i, init_addr_i, init_data_i
   );

   modport slave (
      input  instr_mem_req_i, instr_mem_addr_i,
      output instr_mem_rd_data_o, instr_mem_rd_valid_o,
      input  data_mem_req_i, data_mem_addr_i, data_mem_wr_i,
      input  data_mem_byte_en_i, data_mem_wr_data_i,
      output data_mem_rd_data_o, data_mem_rd_valid_o, data_mem_err_o,
      input  init_we_i, init_addr_i, init_data_i
   );

endinterface

// File: rtl/mem_lat_pipe.sv
// Fixed-depth response delay line. The payload MSB is an error flag that
// advances every cycle; the remaining bits only advance with a valid token.
module mem_lat_pipe #(
   parameter int WIDTH  = 20,
   parameter int STAGES = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data
);

   logic             vld_reg  [STAGES];
   logic [WIDTH-1:0] pay_reg  [STAGES];
   logic             vld_next [STAGES];
   logic [WIDTH-1:0] pay_next [STAGES];

   generate
      for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
         if (gi == 0) begin : g_head
            assign vld_next[gi] = in_valid;
            assign pay_next[gi] = in_data;
         end else begin : g_link
            assign vld_next[gi] = vld_reg[gi-1];
            assign pay_next[gi] = pay_reg[gi-1];
         end
      end
   endgenerate

   // Data bits hold while no token passes, so the last stage keeps the
   // most recent valid response on the output.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < STAGES; i++) begin
            vld_reg[i] <= 1'b0;
            pay_reg[i] <= '0;
         end
      end else begin
         for (int i = 0; i < STAGES; i++) begin
            vld_reg[i]          <= vld_next[i];
            pay_reg[i][WIDTH-1] <= pay_next[i][WIDTH-1];
            if (vld_next[i]) begin
               pay_reg[i][WIDTH-2:0] <= pay_next[i][WIDTH-2:0];
            end
         end
      end
   end

   assign out_valid = vld_reg[STAGES-1];
   assign out_data  = pay_reg[STAGES-1];

endmodule

// File: rtl/mem_latency_model.sv
// Dual-array (IMEM/DMEM) memory model with a fixed, fully pipelined read
// latency, byte-lane writes, out-of-range flagging and an IMEM backdoor.
module mem_latency_model
   import mem_model_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DEPTH   = DEPTH_DEF,
   parameter int LATENCY = LATENCY_DEF
) (
   input  logic               clk,
   input  logic               reset,
   mem_latency_model_if.slave bus
);

   localparam int IDX_W = $clog2(DEPTH);

   generate
      if (!latency_legal(LATENCY)) begin : g_bad_latency
         $error("mem_latency_model: LATENCY %0d outside %0d..%0d", LATENCY, LATENCY_MIN, LATENCY_MAX);
      end
      if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
         $error("mem_latency_model: DEPTH %0d is not a power of two", DEPTH);
      end
      if (DATA_W <= LANE0_MSB + 1) begin : g_bad_width
         $error("mem_latency_model: DATA_W %0d leaves no upper lane", DATA_W);
      end
      if (ADDR_W < IDX_W) begin : g_bad_addr
         $error("mem_latency_model: ADDR_W %0d cannot index DEPTH %0d", ADDR_W, DEPTH);
      end
   endgenerate

   logic [DATA_W-1:0] imem [DEPTH];
   logic [DATA_W-1:0] dmem [DEPTH];

   logic [IDX_W-1:0]  f_idx;
   logic [IDX_W-1:0]  i_idx;
   logic [IDX_W-1:0]  d_idx;
   logic              f_in_range;
   logic              i_in_range;
   logic              d_in_range;
   logic [DATA_W-1:0] f_rd_data;
   logic [DATA_W-1:0] d_rd_data;
   logic              d_rd_req;
   logic              d_wr_req;
   logic              d_err;
   lane_sel_e         lanes;

   // Anything above the index bits makes an address out of range.
   assign f_in_range = (bus.instr_mem_addr_i >> IDX_W) == '0;
   assign i_in_range = (bus.init_addr_i >> IDX_W) == '0;
   assign d_in_range = (bus.data_mem_addr_i >> IDX_W) == '0;
   assign f_idx      = bus.instr_mem_addr_i[IDX_W-1:0];
   assign i_idx      = bus.init_addr_i[IDX_W-1:0];
   assign d_idx      = bus.data_mem_addr_i[IDX_W-1:0];

   assign d_rd_req = bus.data_mem_req_i & ~bus.data_mem_wr_i;
   assign d_wr_req = bus.data_mem_req_i & bus.data_mem_wr_i & d_in_range;
   assign d_err    = bus.data_mem_req_i & ~d_in_range;
   assign lanes    = lane_sel_e'(bus.data_mem_byte_en_i);

   always_comb begin
      f_rd_data = '0;
      d_rd_data = '0;
      if (f_in_range) f_rd_data = imem[f_idx];
      if (d_in_range) d_rd_data = dmem[d_idx];
   end

   // Arrays are never cleared; reset only blocks writes while it is high.
   always_ff @(posedge clk or posedge reset) begin
      if (!reset) begin
         if (bus.init_we_i && i_in_range) begin
            imem[i_idx] <= bus.init_data_i;
         end
         if (d_wr_req) begin
            if (lanes inside {LANE_LO, LANE_ALL}) begin
               dmem[d_idx][LANE0_MSB:0] <= bus.data_mem_wr_data_i[LANE0_MSB:0];
            end
            if (lanes inside {LANE_HI, LANE_ALL}) begin
               dmem[d_idx][DATA_W-1:LANE0_MSB+1] <= bus.data_mem_wr_data_i[DATA_W-1:LANE0_MSB+1];
            end
         end
      end
   end

   logic              f_vld;
   logic [DATA_W:0]   f_pay;
   logic              d_vld;
   logic [DATA_W:0]   d_pay;

   mem_lat_pipe #(
      .WIDTH  (DATA_W + 1),
      .STAGES (LATENCY)
   ) u_fetch_pipe (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (bus.instr_mem_req_i),
      .in_data   ({1'b0, f_rd_data}),
      .out_valid (f_vld),
      .out_data  (f_pay)
   );

   mem_lat_pipe #(
      .WIDTH  (DATA_W + 1),
      .STAGES (LATENCY)
   ) u_data_pipe (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (d_rd_req),
      .in_data   ({d_err, d_rd_data}),
      .out_valid (d_vld),
      .out_data  (d_pay)
   );

   // The fetch pipe's error bit is constant low, so it never masks a valid.
   assign bus.instr_mem_rd_valid_o = f_vld & ~f_pay[DATA_W];
   assign bus.instr_mem_rd_data_o  = f_pay[DATA_W-1:0];
   assign bus.data_mem_rd_valid_o  = d_vld;
   assign bus.data_mem_rd_data_o   = d_pay[DATA_W-1:0];
   assign bus.data_mem_err_o       = d_pay[DATA_W];

endmodule

// File: doc/mem_latency_model.md
MEM_LATENCY_MODEL -- requirements
Module: mem_latency_model

Interface
REQ-001 SHALL have parameter DATA_W, default 19, meaning the memory word width.
REQ-002 SHALL have parameter ADDR_W, default 19, meaning the address width.
REQ-003 SHALL have parameter DEPTH, default 256 (power of two), meaning the words per array.
REQ-004 SHALL have parameter LATENCY, default 1, legal 1..4, meaning the request-to-data cycles.
REQ-005 SHALL have ports: clk  in  1  clock, all logic on rising edge; one clock; reset is asynchronous and active-high.
REQ-006 SHALL have port: reset  in  1  asynchronous active-high reset.
REQ-007 SHALL have ports: instr_mem_req_i  in  1  fetch request; instr_mem_addr_i  in  ADDR_W  fetch word address.
REQ-008 SHALL have ports: instr_mem_rd_data_o  out  DATA_W  fetch data; instr_mem_rd_valid_o  out  1  fetch data valid.
REQ-009 SHALL have ports: data_mem_req_i  in  1  data request; data_mem_addr_i  in  ADDR_W  word address; data_mem_wr_i  in  1  1=write 0=read.
REQ-010 SHALL have ports: data_mem_byte_en_i  in  2  lane enables; data_mem_wr_data_i  in  DATA_W  write data.
REQ-011 SHALL have ports: data_mem_rd_data_o  out  DATA_W  read data; data_mem_rd_valid_o  out  1  read valid; data_mem_err_o  out  1  out-of-range pulse.
REQ-012 SHALL have ports: init_we_i  in  1  backdoor IMEM write; init_addr_i  in  ADDR_W; init_data_i  in  DATA_W.

Function
REQ-013 SHALL hold two separate arrays, IMEM and DMEM, each DEPTH x DATA_W.
REQ-014 SHALL sample a request on every clk edge where its req is high, and SHALL accept one request per port per cycle (fully pipelined, no stall).
REQ-015 SHALL assert the read valid exactly LATENCY cycles after the sampling edge, for one cycle per request; back-to-back requests SHALL give back-to-back valids in order.
REQ-016 SHALL read array contents at the sampling edge, and SHALL hold the data through the delay line.
REQ-017 SHALL keep rd_data at the last valid value while valid is low.
REQ-018 SHALL commit a DMEM write at the sampling edge, with no rd_valid generated.
REQ-019 SHALL write lane 0 (bits 7:0) when byte_en[0]=1, and SHALL write lane 1 (bits DATA_W-1:8) when byte_en[1]=1; byte_en=00 SHALL leave the word unchanged.
REQ-020 SHALL return the new value for a DMEM read in cycle N+1 after a write in cycle N to the same address.
REQ-021 SHALL treat an address >= DEPTH as out-of-range: a read SHALL return 0 with valid; a write SHALL be dropped; a data-port access SHALL pulse data_mem_err_o at the cycle its read valid would occur; a fetch SHALL not raise err.
REQ-022 SHALL apply an init_we_i write to IMEM at the edge; a fetch of the same address in the same cycle SHALL return the old value (read-first).
REQ-023 SHALL index arrays with addr[$clog2(DEPTH)-1:0] after the range check.

Reset
REQ-024 SHALL clear all valid stages, rd_data outputs and data_mem_err_o to 0 while reset is high.
REQ-025 SHALL drop in-flight reads on reset assertion mid-operation; no valid SHALL appear for them after release.
REQ-026 SHALL not reset array contents.
REQ-027 SHALL ignore requests and init writes while reset is high.

Structure
REQ-028 SHALL take default widths, the LATENCY bounds and the lane-boundary constant (LANE0_MSB=7) from package mem_model_pkg.
REQ-029 SHALL implement the delay line as sub-module mem_lat_pipe (parametrised DATA_W+1 wide with an err bit, LATENCY deep), instantiated once per port.
REQ-030 SHALL flag an illegal LATENCY at elaboration.

Verification
REQ-031 Bench SHALL cover: init IMEM[5]=19'h1ABCD, then fetch addr 5 with LATENCY=3 -> instr_mem_rd_valid_o high exactly 3 cycles later with data 19'h1ABCD.
REQ-032 Bench SHALL cover: DMEM[8]=19'h7FFFF, then write 19'h12345 with byte_en=01, then read addr 8 the next cycle -> 19'h7FF45.
REQ-033 Bench SHALL cover: four back-to-back reads of addr 0..3 holding 19'h11460..19'h11463 -> four consecutive valids with in-order data.
REQ-034 Bench SHALL cover: data read of addr 19'h00100 with DEPTH=256 -> data 0, valid and err both high at the same cycle; a write to the same address leaves DMEM unchanged.
REQ-035 Bench SHALL cover: reset asserted 1 cycle after a read with LATENCY=4 -> no valid after release, outputs 0, and DMEM contents preserved on a following read.
REQ-036 Bench SHALL cover: init_we_i writing 19'h00001 to addr 2 while fetching addr 2 -> the fetch returns the old value; a fetch the next cycle returns 19'h00001.
